starfield_scroll_ctrl: RTL and testbench
========================================

// Module: starfield_scroll_ctrl
// PURPOSE
// Sequences the step-enable of the 16-bit starfield LFSR, one step per pixel inside the square star window.
// Scroll speed and direction are set per frame:
// - forward scroll: extra LFSR steps are issued in the post-window blanking period;
// - reverse scroll: steps are withheld at the start of the window.
// Sits between hvsync_generator (hpos/vpos) and the LFSR enable/reload inputs.
// PARAMETERS
// WIN_BITS  9  window side = 2^WIN_BITS pixels; window = hpos,vpos < 2^WIN_BITS
// SPEED_W   4  width of speed input; max extra/withheld steps per frame = 2^SPEED_W-1
// FRAME_W   8  width of frame counter
// PORTS
// clk          in   1         pixel clock
// reset        in   1         async, active-high
// hpos         in   10        horizontal position from hvsync_generator
// vpos         in   10        vertical position from hvsync_generator
// speed        in   SPEED_W   steps of scroll per frame; sampled at frame boundary
// dir          in   1         0 = forward (extra steps), 1 = reverse (withheld steps)
// freeze       in   1         1 = hold LFSR entirely for next frame (pattern static)
// reload_req   in   1         request LFSR seed reload (used only with STARFIELD_RELOAD_EN)
// lfsr_enable  out  1         LFSR step enable, registered
// lfsr_reload  out  1         one-cycle LFSR reload pulse, registered
// in_window    out  1         registered: current pixel inside star window
// frame_count  out  FRAME_W   frames completed, wraps 2^FRAME_W-1 -> 0
// BEHAVIOUR
// - Reset (async): state=WAIT, lfsr_enable=0, lfsr_reload=0, in_window=0, frame_count=0, shadow speed/dir/freeze=0, skip/extra counters=0.
// - win = (hpos >> WIN_BITS)==0 && (vpos >> WIN_BITS)==0; in_window = win registered (1-cycle latency).
// - Frame boundary event FB: hpos==0 && vpos==2^WIN_BITS. At FB:
//   - latch speed/dir/freeze into shadow regs;
//   - frame_count += 1 (wraps);
//   - enter ADJUST. Mid-frame input changes have no effect.
// - States: WAIT -> WINDOW when hpos==0 && vpos==0; WINDOW -> WAIT on FB after adjust; ADJUST -> WAIT when extra count hits 0.
// - WINDOW:
//   - lfsr_enable = win registered (same cycle as in_window) && !freeze_s && skip==0;
//   - skip loads speed_s at window entry when dir_s=1, else 0; decrements on each in-window pixel while nonzero;
//   - result: the first speed_s window pixels produce no step.
// - ADJUST:
//   - extra count loads speed_s if dir_s=0 && !freeze_s, else 0;
//   - lfsr_enable=1 for exactly that many consecutive cycles starting the cycle after FB, then 0; then -> WAIT.
//   - speed_s=0 -> zero ADJUST cycles, immediate WAIT.
// - WAIT: lfsr_enable=0.
// - Net steps per frame: forward = 2^(2*WIN_BITS)+speed_s; reverse = 2^(2*WIN_BITS)-speed_s; freeze = 0.
// - speed_s >= window pixel count (reverse): skip clamps; whole window yields 0 steps, no underflow.
// - Reset mid-frame: outputs return to reset values immediately; the first WINDOW entry after the first frame start (hpos==0 && vpos==0) uses speed=0, dir=0, freeze=0 until the next FB.
// - FB during ADJUST cannot occur (>=1 line apart); nonetheless FB always restarts ADJUST.
// CONFIGURATION
// STARFIELD_RELOAD_EN defined:
// - reload_req is sticky-latched (set on any cycle reload_req=1; cleared on issue);
// - at the next hpos==0 && vpos==0, lfsr_reload pulses for 1 cycle and lfsr_enable is 0 that cycle;
// - the latch is cleared;
// - frame_count resets to 0 on the same edge.
// STARFIELD_RELOAD_EN undefined: reload_req ignored, lfsr_reload tied 0, no latch logic.
// TESTING
// 1. Reset mid-window, release -> all outputs 0; at FB, frame_count=1; every cycle in any frame, lfsr_enable==in_window; window yields 262144 enables.
// 2. speed=5, dir=0 before FB -> ADJUST enables exactly 5 consecutive cycles after FB; next frame total 262149.
// 3. speed=3, dir=1 -> first 3 window pixels (hpos 0..2, vpos 0) enable=0; frame total 262141.
// 4. freeze=1 latched at FB -> zero enables for the whole next frame; freeze deasserted mid-frame has no effect.
// 5. speed changed 2->7 at vpos=100 -> current frame unaffected; 7 applied from next FB.
// 6. STARFIELD_RELOAD_EN: 1-cycle reload_req at vpos=300 -> single lfsr_reload pulse at next frame start, enable=0 that cycle, frame_count=0.

Source files
------------

// File: rtl/starfield_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : starfield_scroll_ctrl
// Purpose  : Step-enable sequencer for the starfield LFSR with per-frame scroll
//            speed/direction. Optional macro STARFIELD_RELOAD_EN adds seed reload.
// Revision : 1.0
// ============================================================================
module starfield_scroll_ctrl #(
    parameter int WIN_BITS = 9,
    parameter int SPEED_W  = 4,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         hpos,
    input  logic [9:0]         vpos,
    input  logic [SPEED_W-1:0] speed,
    input  logic               dir,
    input  logic               freeze,
    input  logic               reload_req,
    output logic               lfsr_enable,
    output logic               lfsr_reload,
    output logic               in_window,
    output logic [FRAME_W-1:0] frame_count
);

    localparam logic [1:0]         c_ST_WAIT   = 2'd0;
    localparam logic [1:0]         c_ST_WINDOW = 2'd1;
    localparam logic [1:0]         c_ST_ADJUST = 2'd2;
    localparam logic [9:0]         c_WIN_SIDE  = 10'(1 << WIN_BITS);
    localparam logic [SPEED_W-1:0] c_SPEED_ONE = SPEED_W'(1);

    logic [1:0]         r_state;
    logic [SPEED_W-1:0] r_speed_s;
    logic               r_dir_s;
    logic               r_freeze_s;
    logic [SPEED_W-1:0] r_skip;
    logic [SPEED_W-1:0] r_extra;

    logic               w_win;
    logic               w_fb;
    logic               w_fs;
    logic [SPEED_W-1:0] w_adj_load;
    logic [SPEED_W-1:0] w_skip_cur;
    logic [SPEED_W-1:0] w_skip_step;
    logic               w_pix_en;
    logic               w_reload_issue;

    assign w_win = ((hpos >> WIN_BITS) == 10'd0) && ((vpos >> WIN_BITS) == 10'd0);
    assign w_fb  = (hpos == 10'd0) && (vpos == c_WIN_SIDE);
    assign w_fs  = (hpos == 10'd0) && (vpos == 10'd0);

    // Adjust length uses the values being latched at this same frame boundary
    assign w_adj_load = (!dir && !freeze) ? speed : '0;

    // On window entry the skip count is loaded and the first pixel consumes it at once
    assign w_skip_cur  = (r_state == c_ST_WAIT) ? (r_dir_s ? r_speed_s : '0) : r_skip;
    assign w_skip_step = (w_skip_cur != '0) ? (w_skip_cur - c_SPEED_ONE) : '0;
    assign w_pix_en    = (w_skip_cur == '0) && !r_freeze_s && !w_reload_issue;

`ifdef STARFIELD_RELOAD_EN
    logic r_reload_pend;

    assign w_reload_issue = w_fs && r_reload_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reload_pend <= 1'b0;
            lfsr_reload   <= 1'b0;
        end else begin
            r_reload_pend <= reload_req || (r_reload_pend && !w_reload_issue);
            lfsr_reload   <= w_reload_issue;
        end
    end
`else
    logic w_unused_reload;

    assign w_unused_reload = reload_req;
    assign w_reload_issue  = 1'b0;
    assign lfsr_reload     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_WAIT;
            r_speed_s   <= '0;
            r_dir_s     <= 1'b0;
            r_freeze_s  <= 1'b0;
            r_skip      <= '0;
            r_extra     <= '0;
            lfsr_enable <= 1'b0;
            in_window   <= 1'b0;
            frame_count <= '0;
        end else begin
            in_window <= w_win;
            if (w_fb) begin
                r_speed_s   <= speed;
                r_dir_s     <= dir;
                r_freeze_s  <= freeze;
                frame_count <= frame_count + 1'b1;
                r_skip      <= '0;
                r_extra     <= w_adj_load;
                lfsr_enable <= (w_adj_load != '0);
                r_state     <= (w_adj_load != '0) ? c_ST_ADJUST : c_ST_WAIT;
            end else begin
                lfsr_enable <= 1'b0;
                case (r_state)
                    c_ST_WAIT: begin
                        if (w_fs) begin
                            r_state     <= c_ST_WINDOW;
                            r_skip      <= w_skip_step;
                            lfsr_enable <= w_pix_en;
                        end
                    end
                    c_ST_WINDOW: begin
                        if (w_win) begin
                            r_skip      <= w_skip_step;
                            lfsr_enable <= w_pix_en;
                        end
                    end
                    c_ST_ADJUST: begin
                        // The first extra step was already issued at the boundary edge
                        if (r_extra > c_SPEED_ONE) begin
                            r_extra     <= r_extra - c_SPEED_ONE;
                            lfsr_enable <= 1'b1;
                        end else begin
                            r_extra <= '0;
                            r_state <= c_ST_WAIT;
                        end
                    end
                    default: r_state <= c_ST_WAIT;
                endcase
                if (w_reload_issue) begin
                    frame_count <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_starfield_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_starfield_scroll_ctrl
// Purpose  : Directed bench on a reduced raster (8x10, 4x4 star window).
// Revision : 1.0
// ============================================================================
module tb_starfield_scroll_ctrl;

    localparam int WIN_BITS  = 2;
    localparam int SPEED_W   = 5;
    localparam int FRAME_W   = 8;
    localparam int H_TOTAL   = 8;
    localparam int V_TOTAL   = 10;
    localparam int FRAME_PIX = H_TOTAL * V_TOTAL;
    localparam int FB_PIX    = (1 << WIN_BITS) * H_TOTAL;

    logic               clk;
    logic               reset;
    logic [9:0]         hpos;
    logic [9:0]         vpos;
    logic [SPEED_W-1:0] speed;
    logic               dir;
    logic               freeze;
    logic               reload_req;
    logic               lfsr_enable;
    logic               lfsr_reload;
    logic               in_window;
    logic [FRAME_W-1:0] frame_count;

    int         tests;
    int         failed;
    int         pix;
    int         n_en;
    int         n_neq;
    int         n_rl;
    logic [7:0] exp_fc;
    logic       en_hist [0:FRAME_PIX-1];
    logic       rl_hist [0:FRAME_PIX-1];
    logic [7:0] fc_hist [0:FRAME_PIX-1];

    starfield_scroll_ctrl #(
        .WIN_BITS (WIN_BITS),
        .SPEED_W  (SPEED_W),
        .FRAME_W  (FRAME_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hpos        (hpos),
        .vpos        (vpos),
        .speed       (speed),
        .dir         (dir),
        .freeze      (freeze),
        .reload_req  (reload_req),
        .lfsr_enable (lfsr_enable),
        .lfsr_reload (lfsr_reload),
        .in_window   (in_window),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One pixel: the sample after the edge belongs to the pixel driven before it
    task automatic tick();
        int lbl;
        lbl = pix;
        @(posedge clk);
        #1;
        en_hist[lbl] = lfsr_enable;
        rl_hist[lbl] = lfsr_reload;
        fc_hist[lbl] = frame_count;
        if (lfsr_enable === 1'b1) n_en++;
        if (lfsr_enable !== in_window) n_neq++;
        if (lfsr_reload === 1'b1) n_rl++;
        if (reset) exp_fc = 8'd0;
        else if (lbl == FB_PIX) exp_fc = exp_fc + 8'd1;
        pix  = (pix + 1) % FRAME_PIX;
        hpos = 10'(pix % H_TOTAL);
        vpos = 10'(pix / H_TOTAL);
    endtask

    task automatic clear_counts();
        n_en  = 0;
        n_neq = 0;
        n_rl  = 0;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < FRAME_PIX && pix != target; i++) tick();
    endtask

    task automatic run_frame();
        clear_counts();
        repeat (FRAME_PIX) tick();
    endtask

    function automatic int adj_run();
        int n;
        n = 0;
        for (int i = FB_PIX; i < FRAME_PIX; i++) begin
            if (en_hist[i] !== 1'b1) break;
            n++;
        end
        return n;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        clear_counts();
        run_to(FB_PIX);
        tests++; if (n_en !== 0) begin failed++; $display("FAIL reset_pre_frame_en: got %0d expected 0", n_en); end
        tick();
        tests++; if (frame_count !== 8'd1) begin failed++; $display("FAIL reset_first_fb_count: got %0d expected 1", frame_count); end
        run_to(10);
        tests++; if (lfsr_enable !== 1'b1 || in_window !== 1'b1) begin failed++; $display("FAIL window_pixel: got en=%b win=%b expected 1/1", lfsr_enable, in_window); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (lfsr_enable !== 1'b0) begin failed++; $display("FAIL async_reset_en: got %b expected 0", lfsr_enable); end
        tests++; if (in_window !== 1'b0) begin failed++; $display("FAIL async_reset_win: got %b expected 0", in_window); end
        tests++; if (frame_count !== 8'd0) begin failed++; $display("FAIL async_reset_count: got %0d expected 0", frame_count); end
        tests++; if (lfsr_reload !== 1'b0) begin failed++; $display("FAIL async_reset_reload: got %b expected 0", lfsr_reload); end
        repeat (2) tick();
        reset = 1'b0;
        clear_counts();
        run_to(FB_PIX);
        tests++; if (n_en !== 0) begin failed++; $display("FAIL reset_midwin_en: got %0d expected 0", n_en); end
        run_frame();
        tests++; if (n_en !== 16) begin failed++; $display("FAIL plain_frame_en: got %0d expected 16", n_en); end
        tests++; if (n_neq !== 0) begin failed++; $display("FAIL en_vs_window: got %0d differing cycles expected 0", n_neq); end
        tests++; if (frame_count !== 8'd1) begin failed++; $display("FAIL plain_frame_count: got %0d expected 1", frame_count); end
    endtask

    task automatic test_forward();
        speed = 5'd5;
        dir   = 1'b0;
        run_frame();
        tests++; if (n_en !== 21) begin failed++; $display("FAIL fwd_total: got %0d expected 21", n_en); end
        tests++; if (adj_run() !== 5) begin failed++; $display("FAIL fwd_adjust_run: got %0d expected 5", adj_run()); end
        tests++; if (frame_count !== 8'd2 || frame_count !== exp_fc) begin failed++; $display("FAIL fwd_count: got %0d expected 2", frame_count); end
    endtask

    task automatic test_reverse();
        speed = 5'd3;
        dir   = 1'b1;
        run_frame();
        tests++; if (n_en !== 13) begin failed++; $display("FAIL rev_total: got %0d expected 13", n_en); end
        tests++; if ({en_hist[0], en_hist[1], en_hist[2], en_hist[3]} !== 4'b0001) begin failed++; $display("FAIL rev_first_pixels: got %b%b%b%b expected 0001", en_hist[0], en_hist[1], en_hist[2], en_hist[3]); end
        tests++; if (adj_run() !== 0) begin failed++; $display("FAIL rev_no_adjust: got %0d expected 0", adj_run()); end
    endtask

    task automatic test_freeze();
        speed  = 5'd5;
        dir    = 1'b0;
        freeze = 1'b1;
        clear_counts();
        tick();
        freeze = 1'b0;
        speed  = 5'd0;
        repeat (FRAME_PIX - 1) tick();
        tests++; if (n_en !== 0) begin failed++; $display("FAIL freeze_total: got %0d expected 0", n_en); end
        run_frame();
        tests++; if (n_en !== 16) begin failed++; $display("FAIL unfreeze_total: got %0d expected 16", n_en); end
    endtask

    task automatic test_speed_change();
        speed = 5'd2;
        dir   = 1'b0;
        clear_counts();
        repeat (10) tick();
        speed = 5'd7;
        repeat (FRAME_PIX - 10) tick();
        tests++; if (n_en !== 18) begin failed++; $display("FAIL midframe_total: got %0d expected 18", n_en); end
        tests++; if (adj_run() !== 2) begin failed++; $display("FAIL midframe_adjust: got %0d expected 2", adj_run()); end
        run_frame();
        tests++; if (n_en !== 23) begin failed++; $display("FAIL next_frame_total: got %0d expected 23", n_en); end
        tests++; if (adj_run() !== 7) begin failed++; $display("FAIL next_frame_adjust: got %0d expected 7", adj_run()); end
    endtask

    task automatic test_clamp();
        dir   = 1'b1;
        speed = 5'd20;
        run_frame();
        tests++; if (n_en !== 0) begin failed++; $display("FAIL clamp20_total: got %0d expected 0", n_en); end
        speed = 5'd16;
        run_frame();
        tests++; if (n_en !== 0) begin failed++; $display("FAIL clamp16_total: got %0d expected 0", n_en); end
        speed = 5'd15;
        run_frame();
        tests++; if (n_en !== 1 || en_hist[27] !== 1'b1) begin failed++; $display("FAIL rev15: got total %0d last %b expected 1/1", n_en, en_hist[27]); end
    endtask

    task automatic test_max_forward();
        dir   = 1'b0;
        speed = 5'd31;
        run_frame();
        tests++; if (n_en !== 47) begin failed++; $display("FAIL max_fwd_total: got %0d expected 47", n_en); end
        tests++; if (adj_run() !== 31) begin failed++; $display("FAIL max_fwd_adjust: got %0d expected 31", adj_run()); end
        speed = 5'd0;
    endtask

    task automatic test_frame_wrap();
        int n;
        tests++; if (frame_count !== exp_fc) begin failed++; $display("FAIL count_track: got %0d expected %0d", frame_count, exp_fc); end
        n = int'(8'd255 - exp_fc);
        repeat (n) run_frame();
        tests++; if (frame_count !== 8'd255) begin failed++; $display("FAIL count_255: got %0d expected 255", frame_count); end
        run_frame();
        tests++; if (frame_count !== 8'd0) begin failed++; $display("FAIL count_wrap: got %0d expected 0", frame_count); end
    endtask

    task automatic test_reload();
        speed = 5'd0;
        dir   = 1'b0;
        clear_counts();
        repeat (16) tick();
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        repeat (FRAME_PIX - 17) tick();
`ifdef STARFIELD_RELOAD_EN
        tests++; if (n_rl !== 1 || rl_hist[0] !== 1'b1) begin failed++; $display("FAIL reload_pulse: got %0d pulses first=%b expected 1/1", n_rl, rl_hist[0]); end
        tests++; if (en_hist[0] !== 1'b0 || n_en !== 15) begin failed++; $display("FAIL reload_enable: got first=%b total %0d expected 0/15", en_hist[0], n_en); end
        tests++; if (fc_hist[0] !== 8'd0) begin failed++; $display("FAIL reload_count: got %0d expected 0", fc_hist[0]); end
`else
        tests++; if (n_rl !== 0) begin failed++; $display("FAIL reload_tied: got %0d pulses expected 0", n_rl); end
        tests++; if (en_hist[0] !== 1'b1 || n_en !== 16) begin failed++; $display("FAIL reload_ignored_en: got first=%b total %0d expected 1/16", en_hist[0], n_en); end
        tests++; if (fc_hist[0] !== 8'd1) begin failed++; $display("FAIL reload_ignored_count: got %0d expected 1", fc_hist[0]); end
`endif
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        pix        = 0;
        exp_fc     = 8'd0;
        reset      = 1'b1;
        hpos       = 10'd0;
        vpos       = 10'd0;
        speed      = '0;
        dir        = 1'b0;
        freeze     = 1'b0;
        reload_req = 1'b0;
        clear_counts();
        test_reset();
        test_forward();
        test_reverse();
        test_freeze();
        test_speed_change();
        test_clamp();
        test_max_forward();
        test_frame_wrap();
        test_reload();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
